// File: rtl/pc_branch_unit.sv
// Fetch-stage program counter with relative branch target generation,
// a runtime-writable offset LUT and a hardware return-address stack.
module pc_branch_unit #(
  parameter int D           = 12,
  parameter int IDX_W       = 4,
  parameter int STACK_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             halt,
  input  logic             branch_en,
  input  logic             call_en,
  input  logic             ret_en,
  input  logic             imm_or_lut,
  input  logic [IDX_W-1:0] ctrl_in,
  input  logic             lut_we,
  input  logic [IDX_W-1:0] lut_waddr,
  input  logic [D-1:0]     lut_wdata,
  output logic [D-1:0]     pc,
  output logic [D-1:0]     target,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             err
);

  // Pointer counts occupied entries, so it needs one value beyond the depth.
  localparam int SP_W = $clog2(STACK_DEPTH + 1);
  localparam int SI_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [D-1:0]    lut   [2**IDX_W];
  logic [D-1:0]    stack [STACK_DEPTH];
  logic [SP_W-1:0] sp;
  logic [SP_W-1:0] sp_next;
  logic [SI_W-1:0] top_idx;
  logic [SI_W-1:0] push_idx;
  logic [D-1:0]    offset;
  logic [D-1:0]    pc_plus1;
  logic [D-1:0]    pc_next;
  logic            err_set;
  logic            push;

  // The LUT read sees the pre-edge contents, so a same-cycle write is not forwarded.
  assign offset      = imm_or_lut ? lut[ctrl_in] : D'($signed(ctrl_in));
  assign target      = pc + offset;
  assign pc_plus1    = pc + D'(1);
  assign stack_empty = (sp == '0);
  assign stack_full  = (sp == SP_W'(STACK_DEPTH));
  assign top_idx     = SI_W'(sp - SP_W'(1));
  assign push_idx    = SI_W'(sp);

  // Next-PC and stack-pointer selection in priority order: halt, ret, call, branch.
  always_comb begin
    pc_next = pc_plus1;
    sp_next = sp;
    err_set = 1'b0;
    push    = 1'b0;
    if (halt) begin
      pc_next = pc;
    end else if (ret_en) begin
      if (!stack_empty) begin
        pc_next = stack[top_idx];
        sp_next = sp - SP_W'(1);
      end else begin
        err_set = 1'b1;
      end
    end else if (call_en) begin
      if (!stack_full) begin
        push    = 1'b1;
        sp_next = sp + SP_W'(1);
        pc_next = target;
      end else begin
        err_set = 1'b1;
      end
    end else if (branch_en) begin
      pc_next = target;
    end
  end

  // PC, stack pointer and sticky error register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc  <= '0;
      sp  <= '0;
      err <= 1'b0;
    end else begin
      pc <= pc_next;
      sp <= sp_next;
      if (err_set) begin
        err <= 1'b1;
      end
    end
  end

  // Offset LUT; writes are accepted regardless of halt.
  always_ff @(posedge clk) begin
    if (reset) begin
      lut <= '{default: '0};
    end else if (lut_we) begin
      lut[lut_waddr] <= lut_wdata;
    end
  end

  // Return-address storage; only the pointer is reset, entries above it are don't-care.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      stack[push_idx] <= pc_plus1;
    end
  end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Scoreboard bench for pc_branch_unit: the driver queues expected post-edge
// state and expected combinational targets; independent monitors compare.
module tb_pc_branch_unit;

  logic        clk;
  logic        reset;
  logic        halt;
  logic        branch_en;
  logic        call_en;
  logic        ret_en;
  logic        imm_or_lut;
  logic [3:0]  ctrl_in;
  logic        lut_we;
  logic [3:0]  lut_waddr;
  logic [11:0] lut_wdata;
  logic [11:0] pc;
  logic [11:0] target;
  logic        stack_full;
  logic        stack_empty;
  logic        err;

  typedef struct {
    string       nm;
    logic [11:0] pc;
    logic        e;
    logic        f;
    logic        r;
  } exp_t;

  typedef struct {
    string       nm;
    logic [11:0] t;
  } tgt_t;

  exp_t q[$];
  tgt_t tq[$];
  int   checks   = 0;
  int   failures = 0;

  pc_branch_unit #(.D(12), .IDX_W(4), .STACK_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .halt       (halt),
    .branch_en  (branch_en),
    .call_en    (call_en),
    .ret_en     (ret_en),
    .imm_or_lut (imm_or_lut),
    .ctrl_in    (ctrl_in),
    .lut_we     (lut_we),
    .lut_waddr  (lut_waddr),
    .lut_wdata  (lut_wdata),
    .pc         (pc),
    .target     (target),
    .stack_full (stack_full),
    .stack_empty(stack_empty),
    .err        (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic clear_inputs();
    halt       = 1'b0;
    branch_en  = 1'b0;
    call_en    = 1'b0;
    ret_en     = 1'b0;
    imm_or_lut = 1'b0;
    ctrl_in    = 4'h0;
    lut_we     = 1'b0;
    lut_waddr  = 4'h0;
    lut_wdata  = 12'h000;
    reset      = 1'b0;
  endtask

  // Queue the state expected after the coming edge, advance one cycle, drop controls.
  task automatic step(input string nm, input logic [11:0] epc,
                      input logic ee, input logic ef, input logic er);
    exp_t x;
    x.nm = nm; x.pc = epc; x.e = ee; x.f = ef; x.r = er;
    q.push_back(x);
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic tgt(input string nm, input logic [11:0] et);
    tgt_t x;
    x.nm = nm; x.t = et;
    tq.push_back(x);
  endtask

  // Registered-state monitor: samples just after each rising edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        checks++;
        if ({pc, stack_empty, stack_full, err} !== {x.pc, x.e, x.f, x.r}) begin
          failures++;
          $display("FAIL %s: got pc=%h empty=%b full=%b err=%b, expected pc=%h empty=%b full=%b err=%b",
                   x.nm, pc, stack_empty, stack_full, err, x.pc, x.e, x.f, x.r);
        end
      end
    end
  end

  // Combinational target monitor: samples late in the low phase, after inputs settle.
  initial begin
    tgt_t x;
    forever begin
      @(negedge clk);
      #4;
      if (tq.size() > 0) begin
        x = tq.pop_front();
        checks++;
        if (target !== x.t) begin
          failures++;
          $display("FAIL %s: got target=%h, expected target=%h", x.nm, target, x.t);
        end
      end
    end
  end

  initial begin
    clear_inputs();
    reset   = 1'b1;
    ctrl_in = 4'hA;
    @(negedge clk);
    reset   = 1'b1;
    ctrl_in = 4'hA;
    tgt("rst_target", 12'hFFA);
    step("reset", 12'h000, 1'b1, 1'b0, 1'b0);

    for (int i = 1; i <= 4; i++) begin
      step("idle", 12'(i), 1'b1, 1'b0, 1'b0);
    end

    branch_en = 1'b1; ctrl_in = 4'd6;
    tgt("br_to10", 12'h00A);
    step("br_to10", 12'h00A, 1'b1, 1'b0, 1'b0);

    branch_en = 1'b1; ctrl_in = 4'b1000;
    tgt("br_neg8", 12'h002);
    step("br_neg8", 12'h002, 1'b1, 1'b0, 1'b0);

    lut_we = 1'b1; lut_waddr = 4'd1; lut_wdata = 12'hFFB;
    step("lut_wr1", 12'h003, 1'b1, 1'b0, 1'b0);

    branch_en = 1'b1; imm_or_lut = 1'b1; ctrl_in = 4'd1;
    tgt("lut_br1", 12'hFFE);
    step("lut_br1", 12'hFFE, 1'b1, 1'b0, 1'b0);

    branch_en = 1'b1; ctrl_in = 4'b0111;
    tgt("br_wrap", 12'h005);
    step("br_wrap", 12'h005, 1'b1, 1'b0, 1'b0);

    lut_we = 1'b1; lut_waddr = 4'd0; lut_wdata = 12'hF9B;
    step("lut_wr0", 12'h006, 1'b1, 1'b0, 1'b0);

    lut_we = 1'b1; lut_waddr = 4'd2; lut_wdata = 12'h0C1;
    step("lut_wr2", 12'h007, 1'b1, 1'b0, 1'b0);

    branch_en = 1'b1; imm_or_lut = 1'b1; ctrl_in = 4'd2;
    tgt("lut_to200", 12'h0C8);
    step("lut_to200", 12'h0C8, 1'b1, 1'b0, 1'b0);

    branch_en = 1'b1; imm_or_lut = 1'b1; ctrl_in = 4'd0;
    tgt("lut_neg101", 12'h063);
    step("lut_neg101", 12'h063, 1'b1, 1'b0, 1'b0);

    branch_en = 1'b1; imm_or_lut = 1'b1; ctrl_in = 4'd3;
    lut_we = 1'b1; lut_waddr = 4'd3; lut_wdata = 12'h009;
    tgt("lut_same_cycle", 12'h063);
    step("lut_same_cycle", 12'h063, 1'b1, 1'b0, 1'b0);

    branch_en = 1'b1; imm_or_lut = 1'b1; ctrl_in = 4'd3;
    tgt("lut_new_val", 12'h06C);
    step("lut_new_val", 12'h06C, 1'b1, 1'b0, 1'b0);

    lut_we = 1'b1; lut_waddr = 4'd4; lut_wdata = 12'hFA7;
    step("lut_wr4", 12'h06D, 1'b1, 1'b0, 1'b0);

    branch_en = 1'b1; imm_or_lut = 1'b1; ctrl_in = 4'd4;
    tgt("lut_to20", 12'h014);
    step("lut_to20", 12'h014, 1'b1, 1'b0, 1'b0);

    call_en = 1'b1; ctrl_in = 4'd5;
    tgt("call_p5", 12'h019);
    step("call_p5", 12'h019, 1'b0, 1'b0, 1'b0);

    ret_en = 1'b1;
    step("ret_once", 12'h015, 1'b1, 1'b0, 1'b0);

    call_en = 1'b1; ctrl_in = 4'd1; step("fill_1", 12'h016, 1'b0, 1'b0, 1'b0);
    call_en = 1'b1; ctrl_in = 4'd1; step("fill_2", 12'h017, 1'b0, 1'b0, 1'b0);
    call_en = 1'b1; ctrl_in = 4'd1; step("fill_3", 12'h018, 1'b0, 1'b0, 1'b0);
    call_en = 1'b1; ctrl_in = 4'd1; step("fill_4", 12'h019, 1'b0, 1'b1, 1'b0);

    call_en = 1'b1; ctrl_in = 4'd5;
    tgt("ovf_target", 12'h01E);
    step("overflow", 12'h01A, 1'b0, 1'b1, 1'b1);

    ret_en = 1'b1; step("pop_1", 12'h019, 1'b0, 1'b0, 1'b1);
    ret_en = 1'b1; step("pop_2", 12'h018, 1'b0, 1'b0, 1'b1);
    ret_en = 1'b1; step("pop_3", 12'h017, 1'b0, 1'b0, 1'b1);
    ret_en = 1'b1; step("pop_4", 12'h016, 1'b1, 1'b0, 1'b1);
    ret_en = 1'b1; step("underflow", 12'h017, 1'b1, 1'b0, 1'b1);

    halt = 1'b1; branch_en = 1'b1; ctrl_in = 4'd5;
    lut_we = 1'b1; lut_waddr = 4'd5; lut_wdata = 12'h010;
    tgt("halt_target", 12'h01C);
    step("halt_hold", 12'h017, 1'b1, 1'b0, 1'b1);

    branch_en = 1'b1; imm_or_lut = 1'b1; ctrl_in = 4'd5;
    tgt("halt_lut_wr", 12'h027);
    step("halt_lut_wr", 12'h027, 1'b1, 1'b0, 1'b1);

    call_en = 1'b1; ctrl_in = 4'd2;
    step("call_p2", 12'h029, 1'b0, 1'b0, 1'b1);

    ret_en = 1'b1; call_en = 1'b1; ctrl_in = 4'd3;
    step("ret_over_call", 12'h028, 1'b1, 1'b0, 1'b1);

    call_en = 1'b1; ctrl_in = 4'd3;
    step("call_then_ret", 12'h02B, 1'b0, 1'b0, 1'b1);

    reset = 1'b1; call_en = 1'b1; ctrl_in = 4'd3;
    step("reset_in_call", 12'h000, 1'b1, 1'b0, 1'b0);

    step("post_reset", 12'h001, 1'b1, 1'b0, 1'b0);

    ret_en = 1'b1;
    step("ret_after_reset", 12'h002, 1'b1, 1'b0, 1'b1);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0 || tq.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d/%0d pending expectations, expected 0/0", q.size(), tq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
